// File: rtl/sdram_cpu_bridge.sv
// Bridge from the picorv32 native memory bus to the SDRAM slot controller.
// Produces the clkref slot reference and issues at most one 16-bit
// controller access per slot, launched at the slot start. Each 32-bit word
// is handled as a low and a high halfword. Every REFRESH_GAP busy slots one
// slot is left idle so the controller can run an auto-refresh.
module sdram_cpu_bridge #(
  parameter int SLOT_LEN    = 16,
  parameter int LAUNCH_PH   = 0,
  parameter int REFRESH_GAP = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        clkref,
  output logic [24:0] ctl_addr,
  output logic        ctl_we,
  output logic        ctl_oe,
  output logic [3:0]  ctl_dqm,
  output logic [31:0] ctl_din,
  input  logic [31:0] ctl_dout,
  input  logic        ctl_ready
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [3:0] PH_LAST   = 4'(SLOT_LEN - 1);
  localparam logic [3:0] PH_LAUNCH = 4'(LAUNCH_PH);
  localparam logic [3:0] PH_REF    = 4'(SLOT_LEN - 4);
  localparam logic [3:0] BUSY_MAX  = 4'(REFRESH_GAP);

  state_t      r_state, w_state_next;
  logic [3:0]  r_ph, w_ph_next;
  logic        r_clkref, r_ready_d, r_mem_ready;
  logic [3:0]  r_busy_cnt;
  logic [22:0] r_addr;
  logic [31:0] r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_read, r_need_hi;
  logic [24:0] r_ctl_addr;
  logic        r_ctl_we, r_ctl_oe;
  logic [1:0]  r_ctl_dqm;
  logic [15:0] r_ctl_din;

  logic        w_at_launch, w_rdy_edge, w_force_idle, w_go, w_active;
  logic        w_in_read, w_in_need_lo, w_in_need_hi, w_accept;
  logic        w_launch_lo, w_launch_hi, w_done_half;
  logic [22:0] w_src_addr;
  logic [31:0] w_src_wdata;
  logic [3:0]  w_src_wstrb;
  logic        w_src_read;
  logic [24:0] w_addr_n;
  logic        w_we_n, w_oe_n, w_mem_ready_n;
  logic [1:0]  w_dqm_n;
  logic [15:0] w_din_n;
  logic [31:0] w_rdata_n;
  logic        w_unused;

  assign w_ph_next    = (r_ph == PH_LAST) ? 4'd0 : r_ph + 4'd1;
  assign w_at_launch  = (r_ph == PH_LAUNCH);
  assign w_rdy_edge   = ctl_ready & ~r_ready_d;
  assign w_force_idle = (r_busy_cnt == BUSY_MAX);
  assign w_go         = w_at_launch & ~w_force_idle;
  assign w_active     = r_ctl_we | r_ctl_oe;
  assign w_in_read    = (mem_wstrb == 4'b0000);
  assign w_in_need_lo = w_in_read | (mem_wstrb[1:0] != 2'b00);
  assign w_in_need_hi = w_in_read | (mem_wstrb[3:2] != 2'b00);
  assign w_done_half  = w_active & w_rdy_edge & ((r_state == S_LO) | (r_state == S_HI));

  // A launch from IDLE uses the live bus; later launches use the latched word
  assign w_src_addr  = (r_state == S_IDLE) ? mem_addr[24:2] : r_addr;
  assign w_src_wdata = (r_state == S_IDLE) ? mem_wdata      : r_wdata;
  assign w_src_wstrb = (r_state == S_IDLE) ? mem_wstrb      : r_wstrb;
  assign w_src_read  = (r_state == S_IDLE) ? w_in_read      : r_read;

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_rdata;
  assign clkref    = r_clkref;
  assign ctl_addr  = r_ctl_addr;
  assign ctl_we    = r_ctl_we;
  assign ctl_oe    = r_ctl_oe;
  assign ctl_dqm   = {2'b00, r_ctl_dqm};
  assign ctl_din   = {16'h0000, r_ctl_din};
  assign w_unused  = ^{mem_addr[31:25], mem_addr[1:0], ctl_dout[31:16]};

  // Slot phase counter, registered slot reference and ready edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph      <= 4'd0;
      r_clkref  <= 1'b0;
      r_ready_d <= 1'b0;
    end else begin
      r_ph      <= w_ph_next;
      r_clkref  <= (w_ph_next >= PH_REF);
      r_ready_d <= ctl_ready;
    end
  end

  // Busy-slot counter: counts consecutive launching slots, clears on any idle slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy_cnt <= 4'd0;
    end else if (w_at_launch) begin
      if (w_launch_lo || w_launch_hi) begin
        r_busy_cnt <= r_busy_cnt + 4'd1;
      end else begin
        r_busy_cnt <= 4'd0;
      end
    end else begin
      r_busy_cnt <= r_busy_cnt;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and launch decisions; launches only happen at the slot start
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_launch_lo  = 1'b0;
    w_launch_hi  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_valid && w_go) begin
          w_accept = 1'b1;
          if (w_in_need_lo) begin
            w_state_next = S_LO;
            w_launch_lo  = 1'b1;
          end else begin
            w_state_next = S_HI;
            w_launch_hi  = 1'b1;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LO: begin
        if (w_active) begin
          if (w_rdy_edge) begin
            w_state_next = r_need_hi ? S_HI : S_DONE;
          end else begin
            w_state_next = S_LO;
          end
        end else if (w_go) begin
          w_launch_lo = 1'b1;
        end else begin
          w_state_next = S_LO;
        end
      end
      S_HI: begin
        if (w_active) begin
          if (w_rdy_edge) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_HI;
          end
        end else if (w_go) begin
          w_launch_hi = 1'b1;
        end else begin
          w_state_next = S_HI;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of controller outputs and read data; address/dqm/din move only at launch
  always_comb begin
    w_addr_n  = r_ctl_addr;
    w_we_n    = r_ctl_we;
    w_oe_n    = r_ctl_oe;
    w_dqm_n   = r_ctl_dqm;
    w_din_n   = r_ctl_din;
    w_rdata_n = r_rdata;
    if (w_launch_lo) begin
      w_addr_n = {w_src_addr, 2'b00};
      w_we_n   = ~w_src_read;
      w_oe_n   = w_src_read;
      w_dqm_n  = w_src_wstrb[1:0];
      w_din_n  = w_src_wdata[15:0];
    end else if (w_launch_hi) begin
      w_addr_n = {w_src_addr, 2'b10};
      w_we_n   = ~w_src_read;
      w_oe_n   = w_src_read;
      w_dqm_n  = w_src_wstrb[3:2];
      w_din_n  = w_src_wdata[31:16];
    end else if (w_done_half) begin
      w_we_n = 1'b0;
      w_oe_n = 1'b0;
      if (r_read && (r_state == S_LO)) begin
        w_rdata_n[15:0] = ctl_dout[15:0];
      end else if (r_read && (r_state == S_HI)) begin
        w_rdata_n[31:16] = ctl_dout[15:0];
      end else begin
        w_rdata_n = r_rdata;
      end
    end else begin
      w_we_n = r_ctl_we;
    end
    w_mem_ready_n = (w_state_next == S_DONE) && (r_state != S_DONE);
  end

  // Registered outputs and the request latched when a word is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctl_addr  <= 25'd0;
      r_ctl_we    <= 1'b0;
      r_ctl_oe    <= 1'b0;
      r_ctl_dqm   <= 2'b00;
      r_ctl_din   <= 16'h0000;
      r_rdata     <= 32'h0000_0000;
      r_mem_ready <= 1'b0;
      r_addr      <= 23'd0;
      r_wdata     <= 32'h0000_0000;
      r_wstrb     <= 4'b0000;
      r_read      <= 1'b0;
      r_need_hi   <= 1'b0;
    end else begin
      r_ctl_addr  <= w_addr_n;
      r_ctl_we    <= w_we_n;
      r_ctl_oe    <= w_oe_n;
      r_ctl_dqm   <= w_dqm_n;
      r_ctl_din   <= w_din_n;
      r_rdata     <= w_rdata_n;
      r_mem_ready <= w_mem_ready_n;
      if (w_accept) begin
        r_addr    <= mem_addr[24:2];
        r_wdata   <= mem_wdata;
        r_wstrb   <= mem_wstrb;
        r_read    <= w_in_read;
        r_need_hi <= w_in_need_hi;
      end
    end
  end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Scoreboard bench for sdram_cpu_bridge: expected launches and CPU responses
// are queued by the stimulus and consumed by independent monitors.
module tb_sdram_cpu_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_rdata;
  logic        clkref;
  logic [24:0] ctl_addr;
  logic        ctl_we, ctl_oe;
  logic [3:0]  ctl_dqm;
  logic [31:0] ctl_din;
  logic [31:0] ctl_dout;
  logic        ctl_ready;

  sdram_cpu_bridge #(.SLOT_LEN(16), .LAUNCH_PH(0), .REFRESH_GAP(7)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .clkref(clkref), .ctl_addr(ctl_addr), .ctl_we(ctl_we), .ctl_oe(ctl_oe),
    .ctl_dqm(ctl_dqm), .ctl_din(ctl_din), .ctl_dout(ctl_dout), .ctl_ready(ctl_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Bench copy of the slot phase and slot number
  int tb_ph;
  int slot;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_ph <= 0;
      slot  <= 0;
    end else if (tb_ph == 15) begin
      tb_ph <= 0;
      slot  <= slot + 1;
    end else begin
      tb_ph <= tb_ph + 1;
    end
  end

  // SDRAM controller model: ready pulse DLY cycles after a launch, held hold_cycles
  localparam int DLY = 3;
  logic [15:0] hmem [0:4095];
  logic [11:0] m_idx;
  logic        req_d;
  int          wait_cnt, hold_cnt;
  int          hold_cycles = 1;
  wire         req = ctl_we | ctl_oe;
  assign ctl_ready = (hold_cnt != 0);
  assign ctl_dout  = {16'hDEAD, hmem[m_idx]};

  function automatic logic [15:0] preload(input int i);
    if (i == 'h800) return 16'h1234;
    if (i == 'h801) return 16'hABCD;
    if (i >= 'h80 && i < 'h8A) begin
      if (i % 2 == 0) return 16'(32'h1000 + (i - 'h80) / 2);
      else return 16'(32'h2000 + (i - 'h81) / 2);
    end
    return 16'h0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d    <= 1'b0;
      wait_cnt <= 0;
      hold_cnt <= 0;
      m_idx    <= 12'd0;
      for (int i = 0; i < 4096; i++) hmem[i] <= preload(i);
    end else begin
      req_d <= req;
      if (req && !req_d) begin
        wait_cnt <= DLY;
        m_idx    <= ctl_addr[12:1];
        if (ctl_we && ctl_dqm[0]) hmem[ctl_addr[12:1]][7:0]  <= ctl_din[7:0];
        if (ctl_we && ctl_dqm[1]) hmem[ctl_addr[12:1]][15:8] <= ctl_din[15:8];
      end else if (wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 1;
        if (wait_cnt == 1) hold_cnt <= hold_cycles;
      end else if (hold_cnt != 0) begin
        hold_cnt <= hold_cnt - 1;
      end
    end
  end

  typedef struct packed {
    logic [24:0] addr;
    logic        we;
    logic        oe;
    logic [3:0]  dqm;
    logic [31:0] din;
  } launch_t;
  typedef struct packed {
    logic        is_wr;
    logic [31:0] rdata;
  } resp_t;

  launch_t exp_launch_q[$];
  resp_t   exp_resp_q[$];
  int      launch_slots[$];
  int      ready_slot = -1;

  // Monitor of the controller side: clkref shape, launch phase and content, stability
  initial begin : mon_ctl
    logic        prev_req;
    logic [24:0] cur_addr;
    logic [3:0]  cur_dqm;
    logic [31:0] cur_din;
    launch_t     e;
    prev_req = 1'b0;
    cur_addr = 25'd0;
    cur_dqm  = 4'd0;
    cur_din  = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        chk("clkref", 64'(clkref), 64'(tb_ph >= 12));
        if (req && !prev_req) begin
          chk("launch_phase", 64'(tb_ph), 64'd1);
          chk("launch_we_oe_exclusive", 64'(ctl_we & ctl_oe), 64'd0);
          launch_slots.push_back(slot);
          cur_addr = ctl_addr;
          cur_dqm  = ctl_dqm;
          cur_din  = ctl_din;
          if (exp_launch_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch addr=0x%0h we=%0d oe=%0d", ctl_addr, ctl_we, ctl_oe);
          end else begin
            e = exp_launch_q.pop_front();
            chk("launch_addr", 64'(ctl_addr), 64'(e.addr));
            chk("launch_we", 64'(ctl_we), 64'(e.we));
            chk("launch_oe", 64'(ctl_oe), 64'(e.oe));
            chk("launch_dqm", 64'(ctl_dqm), 64'(e.dqm));
            chk("launch_din", 64'(ctl_din), 64'(e.din));
          end
        end else if (req) begin
          chk("launch_hold", 64'({ctl_addr, ctl_dqm, ctl_din[15:0]}),
              64'({cur_addr, cur_dqm, cur_din[15:0]}));
        end
        prev_req = req;
      end
    end
  end

  // Monitor of the CPU side: pulse width and returned data
  initial begin : mon_cpu
    logic  prev_rdy;
    resp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_rdy = 1'b0;
      end else begin
        if (mem_ready) begin
          chk("ready_single_cycle", 64'(prev_rdy), 64'd0);
          ready_slot = slot;
          if (exp_resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready rdata=0x%0h", mem_rdata);
          end else begin
            e = exp_resp_q.pop_front();
            if (!e.is_wr) chk("mem_rdata", 64'(mem_rdata), 64'(e.rdata));
          end
        end
        prev_rdy = mem_ready;
      end
    end
  end

  task automatic expect_launch(input logic [24:0] a, input logic we, input logic oe,
                               input logic [3:0] dqm, input logic [31:0] din);
    launch_t l;
    l.addr = a; l.we = we; l.oe = oe; l.dqm = dqm; l.din = din;
    exp_launch_q.push_back(l);
  endtask

  task automatic cpu_access(input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [31:0] exp_rd);
    resp_t r;
    bit    got;
    r.is_wr = (ws != 4'd0);
    r.rdata = exp_rd;
    exp_resp_q.push_back(r);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout addr=0x%0h", a);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    bit got;
    int req_slot;
    int exp_off [10] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10};

    idle_cycles(3);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_clkref", 64'(clkref), 64'd0);
    chk("rst_ctl_bus", 64'({ctl_addr, ctl_we, ctl_oe, ctl_dqm}), 64'd0);
    chk("rst_ctl_din", 64'(ctl_din), 64'd0);
    reset = 1'b0;
    idle_cycles(5);

    // Reset while the high half of a read is in flight
    expect_launch(25'h1000, 1'b0, 1'b1, 4'b0000, 32'h0);
    expect_launch(25'h1002, 1'b0, 1'b1, 4'b0000, 32'h0);
    mem_addr = 32'h1000; mem_wstrb = 4'h0; mem_wdata = 32'h0; mem_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ctl_oe && ctl_addr == 25'h1002) begin
        got = 1'b1;
        break;
      end
    end
    chk("reset_hi_reached", 64'(got), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_async_outputs", 64'({mem_ready, clkref, ctl_we, ctl_oe, ctl_addr, ctl_dqm}), 64'd0);
    chk("reset_async_rdata", 64'(mem_rdata), 64'd0);
    chk("reset_async_din", 64'(ctl_din), 64'd0);
    chk("reset_launches_seen", 64'(exp_launch_q.size()), 64'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(7);

    // Plain read, then the same word through ignored address bits
    launch_slots.delete();
    expect_launch(25'h1000, 1'b0, 1'b1, 4'b0000, 32'h0);
    expect_launch(25'h1002, 1'b0, 1'b1, 4'b0000, 32'h0);
    cpu_access(32'h0000_1000, 32'h0, 4'h0, 32'hABCD_1234);
    chk("read_launch_count", 64'(launch_slots.size()), 64'd2);
    if (launch_slots.size() == 2) chk("read_latency_slots", 64'(ready_slot - launch_slots[0]), 64'd1);
    expect_launch(25'h1000, 1'b0, 1'b1, 4'b0000, 32'h0);
    expect_launch(25'h1002, 1'b0, 1'b1, 4'b0000, 32'h0);
    cpu_access(32'hFE00_1003, 32'h0, 4'h0, 32'hABCD_1234);
    idle_cycles(40);

    // High-half-only write raised mid-slot at phase 5
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tb_ph == 5) begin
        got = 1'b1;
        break;
      end
    end
    chk("reach_phase5", 64'(got), 64'd1);
    req_slot = slot;
    launch_slots.delete();
    expect_launch(25'h22, 1'b1, 1'b0, 4'b0011, 32'h0000_DEAD);
    cpu_access(32'h0000_0020, 32'hDEAD_BEEF, 4'b1100, 32'h0);
    chk("write_hi_launch_count", 64'(launch_slots.size()), 64'd1);
    if (launch_slots.size() == 1) begin
      chk("write_next_slot", 64'(launch_slots[0]), 64'(req_slot + 1));
      chk("write_latency_slots", 64'(ready_slot), 64'(launch_slots[0]));
    end
    expect_launch(25'h20, 1'b0, 1'b1, 4'b0000, 32'h0);
    expect_launch(25'h22, 1'b0, 1'b1, 4'b0000, 32'h0);
    cpu_access(32'h0000_0020, 32'h0, 4'h0, 32'hDEAD_0000);
    idle_cycles(40);

    // Full-word write with a two-cycle ready level
    hold_cycles = 2;
    launch_slots.delete();
    expect_launch(25'h40, 1'b1, 1'b0, 4'b0011, 32'h0000_F00D);
    expect_launch(25'h42, 1'b1, 1'b0, 4'b0011, 32'h0000_CAFE);
    cpu_access(32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'h0);
    idle_cycles(40);
    chk("wide_ready_launch_count", 64'(launch_slots.size()), 64'd2);
    hold_cycles = 1;
    expect_launch(25'h40, 1'b0, 1'b1, 4'b0000, 32'h0);
    expect_launch(25'h42, 1'b0, 1'b1, 4'b0000, 32'h0);
    cpu_access(32'h0000_0040, 32'h0, 4'h0, 32'hCAFE_F00D);
    idle_cycles(48);

    // Back-to-back reads: the eighth busy slot is forced idle
    launch_slots.delete();
    for (int k = 0; k < 5; k++) begin
      expect_launch(25'(32'h100 + 4 * k), 1'b0, 1'b1, 4'b0000, 32'h0);
      expect_launch(25'(32'h102 + 4 * k), 1'b0, 1'b1, 4'b0000, 32'h0);
    end
    for (int k = 0; k < 5; k++) begin
      cpu_access(32'h100 + 32'(4 * k), 32'h0, 4'h0, {16'(32'h2000 + k), 16'(32'h1000 + k)});
    end
    chk("refresh_launch_count", 64'(launch_slots.size()), 64'd10);
    if (launch_slots.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("refresh_slot_%0d", i), 64'(launch_slots[i] - launch_slots[0]), 64'(exp_off[i]));
      end
    end
    idle_cycles(20);

    chk("launch_queue_drained", 64'(exp_launch_q.size()), 64'd0);
    chk("resp_queue_drained", 64'(exp_resp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_cpu_bridge.md
Name: sdram_cpu_bridge

Overview:
- Sits between the picorv32 native memory bus and the SDRAM slot controller; it is the controller's only requester.
- Generates the controller's clkref slot reference and launches one 16-bit controller access per 16-cycle slot, aligned to the slot start.
- Splits each 32-bit CPU word into two halfword accesses and merges the read halves.
- Inserts idle slots so the controller issues auto-refresh.

Parameters:
- SLOT_LEN, 16, clk cycles per controller slot; must equal the controller state count.
- LAUNCH_PH, 0, phase at which the bridge changes ctl_we/ctl_oe; corresponds to controller FIRST state.
- REFRESH_GAP, 7, maximum consecutive busy slots before one slot is forced idle; range 1..15.

Ports:
- clk  in  1  system/SDRAM state-machine clock
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  CPU request valid, held until mem_ready
- mem_ready  out  1  one-cycle completion pulse
- mem_addr  in  32  CPU byte address; bits [24:2] used
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 means read
- mem_rdata  out  32  read data, valid while mem_ready=1
- clkref  out  1  slot reference to controller
- ctl_addr  out  25  controller byte address
- ctl_we  out  1  controller write request
- ctl_oe  out  1  controller read request
- ctl_dqm  out  4  byte enables; bits [3:2] always 0
- ctl_din  out  32  write data; bits [31:16] always 0
- ctl_dout  in  32  controller read data; only [15:0] used
- ctl_ready  in  1  controller completion, high ≥1 cycle per access

Behaviour:
- Async reset values:
  - all outputs 0 (mem_ready, mem_rdata, clkref, ctl_* = 0)
  - ph = 0; state IDLE; busy_cnt = 0; ready_d = 0
- Phase counter ph[3:0]:
  - increments every clk and wraps SLOT_LEN-1 -> 0
  - clkref registered: 1 for ph in SLOT_LEN-4..SLOT_LEN-1, else 0
- Ready edge detection:
  - ready_d registers ctl_ready
  - rdy_edge = ctl_ready & ~ready_d
  - only rdy_edge counts; the level is ignored
- IDLE:
  - Acts at ph==LAUNCH_PH when mem_valid=1 and force_idle=0.
  - Latches addr[24:2], wdata, wstrb.
  - Computes need_lo: read, or wstrb[1:0]!=0.
  - Computes need_hi: read, or wstrb[3:2]!=0.
  - Goes to LO if need_lo, else HI.
- LO:
  - Launch happens only at ph==LAUNCH_PH.
  - Launch drives: ctl_addr = {addr[24:2],2'b00}; ctl_oe = read; ctl_we = write; ctl_dqm = {2'b00, wstrb[1:0]}; ctl_din = {16'h0, wdata[15:0]}.
  - Outputs hold until rdy_edge, then ctl_we/ctl_oe clear to 0 on the same edge.
  - On a read, ctl_dout[15:0] is captured into rdata[15:0].
  - Next state is HI if need_hi, else DONE.
- HI:
  - Same as LO, with ctl_addr = {addr[24:2],2'b10}, dqm from wstrb[3:2], din from wdata[31:16].
  - On a read, rdata[31:16] is captured.
  - Next state is DONE.
- DONE:
  - mem_ready=1 for exactly one cycle; mem_rdata = assembled word (write: last value, don't-care).
  - Returns to IDLE.
  - A new request cannot launch earlier than the next LAUNCH_PH.
- Address, dqm and din never change while ctl_we or ctl_oe is high.
- Refresh:
  - At each LAUNCH_PH, busy_cnt increments if a launch occurs, else clears to 0.
  - force_idle = (busy_cnt==REFRESH_GAP).
  - With force_idle set, no launch occurs in that slot (in any state) and busy_cnt clears.
  - This holds mid-word too: the HI launch is deferred one slot.
- Latency, for a request already present before LAUNCH_PH with no forced idle:
  - Read: 2 slots + post-launch ready delay.
  - Single-half write: 1 slot.
- Boundary conditions:
  - mem_valid dropping mid-transaction is illegal; the bridge completes the word regardless.
  - An access with no rdy_edge stays in its state indefinitely (no timeout).
  - mem_addr[31:25] and [1:0] are ignored.
  - A request arriving after LAUNCH_PH waits for the next slot.

Test Plan:
- Reset mid-HI read (assert reset while ctl_oe=1) -> all outputs 0 immediately, state IDLE; next read completes normally.
- Read 0x0000_1000; model returns 0x1234 on lo, 0xABCD on hi -> ctl_addr 0x1000 then 0x1002, ctl_we=0; mem_rdata=0xABCD1234 with mem_ready high exactly 1 cycle.
- Write 0xDEADBEEF, wstrb=4'b1100, addr 0x20 -> single launch, ctl_addr=0x22, ctl_dqm=4'b0011, ctl_din=0x0000DEAD, ctl_we=1; no lo launch; mem_ready after one slot.
- Write wstrb=4'b1111 with ctl_ready held high 2 cycles per access -> exactly two launches, one per rdy_edge, no double advance.
- Back-to-back reads for 10 slots with REFRESH_GAP=7 -> slot 8 has ctl_we=ctl_oe=0 at LAUNCH_PH (hi half deferred); launches resume at slot 9; data correct.
- clkref check -> high for ph 12..15, low for 0..11, period 16 cycles; request raised at ph=5 launches at the next ph=0.
